// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder sequencer.
// Carries the optional sub request when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer driving one external full-adder cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a two's-complement subtract request (bus.sub).
module serial_adder_ctrl #(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_if.slave        bus,
  output logic                 fa_a,
  output logic                 fa_b,
  output logic                 fa_cin,
  input  logic                 fa_s,
  input  logic                 fa_cout
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  sum_sh;
  logic          cy;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  b_load;
  logic          cy_load;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b is a + ~b + 1, so subtract reuses the same adder path.
  assign b_load  = bus.sub ? ~bus.b : bus.b;
  assign cy_load = bus.sub ? 1'b1 : bus.c_in;
`else
  assign b_load  = bus.b;
  assign cy_load = bus.c_in;
`endif

  // The FA sees operand bits only while an operation is in flight.
  assign fa_a   = (state == RUN) ? a_sh[0] : 1'b0;
  assign fa_b   = (state == RUN) ? b_sh[0] : 1'b0;
  assign fa_cin = (state == RUN) ? cy      : 1'b0;

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_sh;
  assign bus.c_out = cy;

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // reset clears the result registers too, since an aborted op must leave no partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= b_load;
            cy     <= cy_load;
            sum_sh <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[W-1:1]};
          cy     <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule
